// File: rtl/dplca_txop_table.sv
// DPLCA TXOP claim table: records used TXOPs per ID and ages FREE/SOFT/HARD claims once per aging period.
// Latency: a recorded txop_end shows in the table and pulses dplca_txop_table_upd on the next clock.
// Backpressure: none; every pulse input is consumed in the clock it arrives, so back-to-back events are all kept.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   dplca_en, plca_en, dplca_aging  tracking runs only while all three are high
//   cycle_start                   one pulse per BEACON; drives the aging counter
//   txop_end, txop_used, curID, plca_node_count   TXOP end event and its qualifiers
//   txop_claim_table_unpacked     256 x 2-bit claim entries (00 FREE, 01 SOFT, 10 HARD)
//   dplca_txop_table_upd          one pulse per recorded TXOP
//   dplca_new_age                 high through the first PLCA cycle of each aging period
//   dplca_txop_id, dplca_txop_node_count   last recorded TXOP ID and its node count
module dplca_txop_table #(
   parameter int AGE_CYCLES = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         dplca_en,
   input  logic         plca_en,
   input  logic         dplca_aging,
   input  logic         cycle_start,
   input  logic         txop_end,
   input  logic         txop_used,
   input  logic [7:0]   curID,
   input  logic [7:0]   plca_node_count,
   output logic [511:0] txop_claim_table_unpacked,
   output logic         dplca_txop_table_upd,
   output logic         dplca_new_age,
   output logic [7:0]   dplca_txop_id,
   output logic [7:0]   dplca_txop_node_count
);

   localparam logic [1:0] ST_OFF        = 2'd0;
   localparam logic [1:0] ST_WAIT_CYCLE = 2'd1;
   localparam logic [1:0] ST_TRACK      = 2'd2;

   localparam logic [1:0] E_FREE = 2'b00;
   localparam logic [1:0] E_SOFT = 2'b01;
   localparam logic [1:0] E_HARD = 2'b10;

   // Counter value at which the next cycle_start closes the aging period.
   localparam logic [7:0] AGE_LAST = 8'(AGE_CYCLES - 1);

   logic [1:0]   state;
   logic [511:0] tbl;
   logic [255:0] seen;
   logic [7:0]   age_cnt;

   logic         enable;
   logic         rec;
   logic         aging;
   logic [8:0]   cur_idx;
   logic [511:0] tbl_nxt;
   logic [255:0] seen_nxt;
   logic [7:0]   age_nxt;
   logic [1:0]   e;

   assign enable  = dplca_en & plca_en & dplca_aging;
   assign rec     = (state == ST_TRACK) & txop_end & (curID < plca_node_count);
   assign aging   = (state == ST_TRACK) & cycle_start & (age_cnt == AGE_LAST);
   assign cur_idx = {curID, 1'b0};

   // The TXOP record is applied before aging so that a TXOP ending on the
   // aging BEACON still counts towards the period being closed.
   always_comb begin
      tbl_nxt  = tbl;
      seen_nxt = seen;
      age_nxt  = age_cnt;
      e        = E_FREE;

      if (rec && txop_used) begin
         seen_nxt[curID] = 1'b1;
         if (tbl[cur_idx +: 2] == E_FREE)
            tbl_nxt[cur_idx +: 2] = E_SOFT;
      end

      if (aging) begin
         age_nxt = 8'd0;
         for (int i = 0; i < 256; i++) begin
            e = tbl_nxt[2*i +: 2];
            if (seen_nxt[i])
               tbl_nxt[2*i +: 2] = E_HARD;
            else if (e == E_HARD)
               tbl_nxt[2*i +: 2] = E_SOFT;
            else
               tbl_nxt[2*i +: 2] = E_FREE;
         end
         seen_nxt = '0;
      end else if (state == ST_TRACK && cycle_start) begin
         age_nxt = age_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state                 <= ST_OFF;
         tbl                   <= '0;
         seen                  <= '0;
         age_cnt               <= 8'd0;
         dplca_txop_table_upd  <= 1'b0;
         dplca_new_age         <= 1'b0;
         dplca_txop_id         <= 8'd0;
         dplca_txop_node_count <= 8'd0;
      end else if (!enable) begin
         state                 <= ST_OFF;
         tbl                   <= '0;
         seen                  <= '0;
         age_cnt               <= 8'd0;
         dplca_txop_table_upd  <= 1'b0;
         dplca_new_age         <= 1'b0;
         dplca_txop_id         <= 8'd0;
         dplca_txop_node_count <= 8'd0;
      end else begin
         dplca_txop_table_upd <= 1'b0;
         case (state)
            ST_OFF: begin
               state <= ST_WAIT_CYCLE;
            end
            ST_WAIT_CYCLE: begin
               // Start tracking aligned to a BEACON so the first period is whole.
               if (cycle_start)
                  state <= ST_TRACK;
            end
            ST_TRACK: begin
               tbl                  <= tbl_nxt;
               seen                 <= seen_nxt;
               age_cnt              <= age_nxt;
               dplca_txop_table_upd <= rec;
               if (rec) begin
                  dplca_txop_id         <= curID;
                  dplca_txop_node_count <= plca_node_count;
               end
               // Aging has priority over clearing the flag.
               if (aging)
                  dplca_new_age <= 1'b1;
               else if (cycle_start)
                  dplca_new_age <= 1'b0;
            end
            default: begin
               state <= ST_OFF;
            end
         endcase
      end
   end

   assign txop_claim_table_unpacked = tbl;

endmodule

// File: doc/dplca_txop_table.md
DPLCA_TXOP_TABLE -- requirements
Module: dplca_txop_table

Interface
REQ-001 Parameter AGE_CYCLES, default 8: PLCA cycles (BEACONs) per aging period, legal range 2..255.
REQ-002 clk  input  1  block clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 dplca_en  input  1  DPLCA enable.
REQ-005 plca_en  input  1  PLCA enable.
REQ-006 dplca_aging  input  1  aging/tracking enable from the DPLCA node-ID state machine.
REQ-007 cycle_start  input  1  one-clock pulse per received or transmitted BEACON.
REQ-008 txop_end  input  1  one-clock pulse at the end of each transmit opportunity.
REQ-009 txop_used  input  1  qualifies txop_end: 1 = carrier/data seen in that TXOP.
REQ-010 curID  input  8  TXOP ID owning the ending opportunity; sampled with txop_end.
REQ-011 plca_node_count  input  8  current node count; sampled with txop_end.
REQ-012 txop_claim_table_unpacked  output  512  entry i at bits [2i+1:2i]: 00 FREE, 01 SOFT, 10 HARD; 11 never driven.
REQ-013 dplca_txop_table_upd  output  1  one-clock pulse per recorded TXOP.
REQ-014 dplca_new_age  output  1  level; high during the first PLCA cycle of a new aging period.
REQ-015 dplca_txop_id  output  8  curID of the most recent recorded TXOP.
REQ-016 dplca_txop_node_count  output  8  plca_node_count captured with dplca_txop_id.

Function
REQ-017 States SHALL be OFF, WAIT_CYCLE, TRACK; enable = dplca_en AND plca_en AND dplca_aging.
REQ-018 Enable low, in any state, SHALL force OFF on the next edge, clear all entries to FREE, clear seen vector, age counter and all outputs.
REQ-019 OFF -> WAIT_CYCLE when enable high; WAIT_CYCLE -> TRACK on cycle_start; txop_end ignored in OFF and WAIT_CYCLE.
REQ-020 In TRACK, txop_end with curID < plca_node_count SHALL be recorded: dplca_txop_id/dplca_txop_node_count loaded, dplca_txop_table_upd pulsed on the following clock (latency 1).
REQ-021 txop_end with curID >= plca_node_count SHALL be discarded: no table change, no upd pulse.
REQ-022 Recorded txop_used=1: seen[curID] set; entry FREE -> SOFT immediately; SOFT/HARD unchanged.
REQ-023 Recorded txop_used=0: table and seen vector unchanged; upd still pulses.
REQ-024 Age counter (8 bit) SHALL increment on each cycle_start in TRACK; on reaching AGE_CYCLES it SHALL wrap to 0 and perform aging in the same clock.
REQ-025 Aging, all 256 entries in parallel: seen[i]=1 -> HARD; else HARD -> SOFT; else SOFT -> FREE; FREE stays FREE; seen vector then cleared.
REQ-026 dplca_new_age SHALL rise on the clock after aging and fall on the clock after the next cycle_start.
REQ-027 Simultaneous txop_end and aging cycle_start: txop_end recorded first (seen bit included in the aging evaluation); its upd pulse coincides with dplca_new_age rising.
REQ-028 Aging cycle_start coincident with a pending new_age clear: aging wins, dplca_new_age stays high.
REQ-029 Back-to-back txop_end pulses on consecutive clocks SHALL each produce one upd pulse; no event lost.

Reset
REQ-030 reset_n low SHALL immediately force OFF, all entries FREE, seen vector 0, age counter 0, dplca_txop_table_upd 0, dplca_new_age 0, dplca_txop_id 0, dplca_txop_node_count 0.
REQ-031 Reset release SHALL take effect on the first rising edge with reset_n high; reset asserted mid-aging leaves no partial update.

Verification
REQ-032 Enable, cycle_start, txop_end curID=3 used=1 node_count=8 -> next clock upd=1, txop_id=3, node_count=8, entry3=SOFT.
REQ-033 ID 3 used in all 8 cycles of a period -> entry3=HARD and new_age=1 after 8th cycle_start; idle two periods -> SOFT, then FREE.
REQ-034 txop_end curID=9, node_count=8 -> no upd, table unchanged.
REQ-035 txop_end curID=5 used=1 together with 8th cycle_start, entry5 FREE -> entry5=HARD, upd and new_age both high next clock.
REQ-036 dplca_aging dropped with entries HARD -> next clock all FREE, state OFF, no upd pulses until TRACK re-entered.
REQ-037 reset_n asserted between txop_end and its upd pulse -> upd never asserts, all outputs 0.
